// File: rtl/tile_draw_if.sv
// -----------------------------------------------------------------------------
// tile_draw_if
//   Handshake bundle between the tile scheduler (master) and the tile draw
//   controller (slave).
//
//   x1..x4     tile left-edge x for rows 0 (top) .. 3 (bottom)
//   y1..y4     tile top-edge y for rows 0 .. 3
//   update     one-cycle pulse, a new board is valid and drawing may begin
//   draw_done  one-cycle pulse from the draw controller, board fully drawn
// -----------------------------------------------------------------------------
interface tile_draw_if;
  logic [7:0] x1;
  logic [7:0] x2;
  logic [7:0] x3;
  logic [7:0] x4;
  logic [6:0] y1;
  logic [6:0] y2;
  logic [6:0] y3;
  logic [6:0] y4;
  logic       update;
  logic       draw_done;

  modport master (
    output x1, x2, x3, x4,
    output y1, y2, y3, y4,
    output update,
    input  draw_done
  );

  modport slave (
    input  x1, x2, x3, x4,
    input  y1, y2, y3, y4,
    input  update,
    output draw_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// -----------------------------------------------------------------------------
// tile_scheduler
//   Game-logic stage of the piano-tiles design. Keeps four tiles, one per
//   30-pixel row, each in one of four 40-pixel lanes. Judges key presses
//   against the bottom tile, scrolls the board on each correct press, and
//   hands the board to the draw controller through tile_draw_if.
//
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      level, starts a game from IDLE or OVER
//   key[3:0]   level, one bit per lane (lane 0 leftmost), already synchronised
//   draw       tile_draw_if master: x1..x4, y1..y4, update out; draw_done in
//   score      correct presses, saturating at 255
//   game_over  high while the game is over
// -----------------------------------------------------------------------------
module tile_scheduler #(
  parameter int unsigned FRAME_DIV      = 833334,
  parameter int unsigned TIMEOUT_FRAMES = 90,
  parameter logic [7:0]  LFSR_SEED      = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  key,
  tile_draw_if.master draw,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [FW-1:0] FRAME_LAST    = FW'(FRAME_DIV - 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_FRAMES);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0]    SEED          = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PUBLISH,
    S_WAIT_DRAW,
    S_PLAY,
    S_SHIFT,
    S_OVER
  } state_t;

  state_t          state_q, state_d;
  // lane_q[0] is the top row, lane_q[3] the bottom row being judged.
  logic [3:0][1:0] lane_q, lane_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [1:0]      fill_cnt_q, fill_cnt_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      key_q;

  logic [3:0]      press;
  logic [7:0]      lfsr_next;
  logic            consume;
  logic            frame_tick;
  logic            press_ok;

  function automatic logic [7:0] lane_to_x(input logic [1:0] lane);
    logic [7:0] x;
    case (lane)
      2'd0:    x = 8'd0;
      2'd1:    x = 8'd40;
      2'd2:    x = 8'd80;
      default: x = 8'd120;
    endcase
    return x;
  endfunction

  // State register and all datapath flops; key_q tracks key every cycle so
  // only rising edges count as presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      lfsr_q     <= SEED;
      fill_cnt_q <= '0;
      frame_q    <= '0;
      timeout_q  <= '0;
      score_q    <= '0;
      key_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      lfsr_q     <= lfsr_d;
      fill_cnt_q <= fill_cnt_d;
      frame_q    <= frame_d;
      timeout_q  <= timeout_d;
      score_q    <= score_d;
      key_q      <= key;
    end
  end

  // Next-state logic. A lane is consumed once per FILL cycle and once in
  // SHIFT; the LFSR steps only then, so its sequence is independent of how
  // long the player takes and carries on across games.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    lfsr_d     = lfsr_q;
    fill_cnt_d = fill_cnt_q;
    frame_d    = frame_q;
    timeout_d  = timeout_q;
    score_d    = score_q;
    consume    = 1'b0;

    press      = key & ~key_q;
    lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    frame_tick = (state_q == S_PLAY) && (frame_q == FRAME_LAST);
    press_ok   = $onehot(press) && (press == (4'b0001 << lane_q[3]));

    case (state_q)
      S_IDLE: begin
        score_d    = '0;
        frame_d    = '0;
        timeout_d  = '0;
        fill_cnt_d = '0;
        if (start) begin
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        consume    = 1'b1;
        fill_cnt_d = fill_cnt_q + 2'd1;
        if (fill_cnt_q == 2'd3) begin
          state_d = S_PUBLISH;
        end
      end

      S_PUBLISH: begin
        state_d = S_WAIT_DRAW;
      end

      S_WAIT_DRAW: begin
        if (draw.draw_done) begin
          state_d = S_PLAY;
        end
      end

      // A correct press is checked before the timeout so that it wins
      // when both happen in the same cycle.
      S_PLAY: begin
        if (frame_tick) begin
          frame_d   = '0;
          timeout_d = timeout_q + TW'(1);
        end else begin
          frame_d   = frame_q + FW'(1);
        end

        if (press != 4'b0000) begin
          if (press_ok) begin
            score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            timeout_d = '0;
            state_d   = S_SHIFT;
          end else begin
            state_d   = S_OVER;
          end
        end else if (frame_tick && (timeout_q + TW'(1) == TIMEOUT_LIMIT)) begin
          state_d = S_OVER;
        end
      end

      S_SHIFT: begin
        consume = 1'b1;
        state_d = S_PUBLISH;
      end

      // Restarting from OVER performs the IDLE entry clearing on the same
      // edge that moves into FILL.
      S_OVER: begin
        if (start) begin
          score_d    = '0;
          frame_d    = '0;
          timeout_d  = '0;
          fill_cnt_d = '0;
          state_d    = S_FILL;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (consume) begin
      lfsr_d = lfsr_next;
      lane_d = {lane_q[2:0], lfsr_next[1:0]};
    end
  end

  // Coordinates decode straight from the lane flops, so they only move
  // when lanes are consumed in FILL or SHIFT.
  always_comb begin
    draw.x1     = lane_to_x(lane_q[0]);
    draw.x2     = lane_to_x(lane_q[1]);
    draw.x3     = lane_to_x(lane_q[2]);
    draw.x4     = lane_to_x(lane_q[3]);
    draw.y1     = 7'd0;
    draw.y2     = 7'd30;
    draw.y3     = 7'd60;
    draw.y4     = 7'd90;
    draw.update = (state_q == S_PUBLISH);
    score       = score_q;
    game_over   = (state_q == S_OVER);
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tile_scheduler
//   Self-checking bench for tile_scheduler with a short frame divider and
//   timeout. A reference model of the lane generator produces each expected
//   board, which is queued when stimulus is driven and popped on update.
// -----------------------------------------------------------------------------
module tb_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] key = 4'b0000;
  logic [7:0] score;
  logic       game_over;

  tile_draw_if dif ();

  tile_scheduler #(
    .FRAME_DIV      (4),
    .TIMEOUT_FRAMES (3),
    .LFSR_SEED      (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .draw      (dif.master),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [59:0] coords;
    logic [7:0]  score;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0] m_lfsr;
  logic [1:0] m_lane [4];
  logic [7:0] m_score;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [59:0] model_coords();
    return {8'(m_lane[0]) * 8'd40, 8'(m_lane[1]) * 8'd40,
            8'(m_lane[2]) * 8'd40, 8'(m_lane[3]) * 8'd40,
            7'd0, 7'd30, 7'd60, 7'd90};
  endfunction

  function automatic logic [59:0] dut_coords();
    return {dif.x1, dif.x2, dif.x3, dif.x4, dif.y1, dif.y2, dif.y3, dif.y4};
  endfunction

  task automatic model_reset();
    m_lfsr  = 8'h01;
    m_score = 8'd0;
    for (int i = 0; i < 4; i++) m_lane[i] = 2'd0;
  endtask

  task automatic model_gen();
    m_lfsr    = lfsr_step(m_lfsr);
    m_lane[3] = m_lane[2];
    m_lane[2] = m_lane[1];
    m_lane[1] = m_lane[0];
    m_lane[0] = m_lfsr[1:0];
  endtask

  task automatic push_expected();
    exp_t e;
    e.coords = model_coords();
    e.score  = m_score;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_update(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (cycles < budget && !seen) begin
      step();
      cycles++;
      if (dif.update === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_draw_done();
    dif.draw_done = 1'b1;
    step();
    dif.draw_done = 1'b0;
  endtask

  // Drives start for one cycle from IDLE or OVER and queues the new board.
  task automatic start_game();
    m_score = 8'd0;
    for (int i = 0; i < 4; i++) model_gen();
    push_expected();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits for an update after start_game and checks the board it carries.
  task automatic finish_start(input string tag);
    int   cyc;
    bit   seen;
    exp_t e;
    wait_update(10, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_update: got no update within 10 cycles, required one", tag);
      sb.delete();
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (dut_coords() !== e.coords || score !== e.score) begin
        n_fail++;
        $display("[TB] FAIL %s_board: got %h/%0d required %h/%0d", tag, dut_coords(), score, e.coords, e.score);
      end
    end
    step();
    pulse_draw_done();
  endtask

  task automatic test_reset();
    int upd;
    model_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (score !== 8'd0 || game_over !== 1'b0 || dif.update !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got score=%0d go=%b upd=%b required 0/0/0", score, game_over, dif.update);
    end
    n_checks++;
    if (dut_coords() !== model_coords()) begin
      n_fail++;
      $display("[TB] FAIL reset_coords: got %h required %h", dut_coords(), model_coords());
    end
    // draw_done while idle must not start anything
    upd = 0;
    pulse_draw_done();
    for (int i = 0; i < 4; i++) begin
      if (dif.update === 1'b1) upd++;
      step();
    end
    n_checks++;
    if (upd != 0 || game_over !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_draw_done: got %0d updates go=%b required 0/0", upd, game_over);
    end
  endtask

  task automatic test_start_fill();
    int   cyc;
    bit   seen;
    exp_t e;
    m_score = 8'd0;
    for (int i = 0; i < 4; i++) model_gen();
    push_expected();
    // start presented in the IDLE cycle; update belongs to the sixth state
    // of IDLE, FILL x4, PUBLISH, i.e. five edges later
    start = 1'b1;
    wait_update(12, cyc, seen);
    start = 1'b0;
    n_checks++;
    if (!seen || cyc != 5) begin
      n_fail++;
      $display("[TB] FAIL start_latency: got seen=%b cycles=%0d required seen=1 cycles=5", seen, cyc);
    end
    n_checks++;
    if ({dif.x1, dif.x2, dif.x3, dif.x4} !== {8'd40, 8'd0, 8'd0, 8'd80}) begin
      n_fail++;
      $display("[TB] FAIL first_board_x: got %0d,%0d,%0d,%0d required 40,0,0,80", dif.x1, dif.x2, dif.x3, dif.x4);
    end
    e = sb.pop_front();
    n_checks++;
    if (dut_coords() !== e.coords || score !== e.score) begin
      n_fail++;
      $display("[TB] FAIL first_board: got %h/%0d required %h/%0d", dut_coords(), score, e.coords, e.score);
    end
    step();
    n_checks++;
    if (dif.update !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL update_single: got update=%b required 0", dif.update);
    end
    step();
    step();
    n_checks++;
    if (dif.update !== 1'b0 || dut_coords() !== e.coords) begin
      n_fail++;
      $display("[TB] FAIL wait_draw_hold: got upd=%b coords=%h required 0/%h", dif.update, dut_coords(), e.coords);
    end
    pulse_draw_done();
  endtask

  task automatic test_correct_press();
    int   cyc;
    bit   seen;
    exp_t e;
    key = 4'b0001 << m_lane[3];
    m_score = m_score + 8'd1;
    model_gen();
    push_expected();
    wait_update(6, cyc, seen);
    key = 4'b0000;
    n_checks++;
    if (!seen || cyc != 2) begin
      n_fail++;
      $display("[TB] FAIL press_latency: got seen=%b cycles=%0d required seen=1 cycles=2", seen, cyc);
    end
    n_checks++;
    if ({dif.x1, dif.x2, dif.x3, dif.x4} !== {8'd120, 8'd40, 8'd0, 8'd0} || score !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL shift_board_x: got %0d,%0d,%0d,%0d score %0d required 120,40,0,0 score 1",
               dif.x1, dif.x2, dif.x3, dif.x4, score);
    end
    e = sb.pop_front();
    n_checks++;
    if (dut_coords() !== e.coords || score !== e.score) begin
      n_fail++;
      $display("[TB] FAIL shift_board: got %h/%0d required %h/%0d", dut_coords(), score, e.coords, e.score);
    end
    step();
    pulse_draw_done();
  endtask

  task automatic test_wrong_press();
    int upd;
    key = 4'b0001 << (m_lane[3] ^ 2'd1);
    step();
    key = 4'b0000;
    n_checks++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrong_lane_over: got game_over=%b required 1", game_over);
    end
    upd = 0;
    for (int i = 0; i < 5; i++) begin
      if (dif.update === 1'b1) upd++;
      step();
    end
    n_checks++;
    if (upd != 0 || score !== m_score || dut_coords() !== model_coords() || game_over !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL over_frozen: got upd=%0d score=%0d coords=%h go=%b required 0/%0d/%h/1",
               upd, score, dut_coords(), m_score, model_coords(), game_over);
    end
  endtask

  task automatic test_timeout();
    int play_cycles;
    int upd;
    start_game();
    finish_start("timeout_start");
    // finish_start already released the board; go back via a fresh game so
    // the key edge lands in WAIT_DRAW
    key = 4'b1111;
    step();
    key = 4'b0000;
    step();
    start_game();
    begin
      int   cyc;
      bit   seen;
      exp_t e;
      wait_update(10, cyc, seen);
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("[TB] FAIL restart_update: got no update within 10 cycles, required one");
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (dut_coords() !== e.coords || score !== 8'd0) begin
          n_fail++;
          $display("[TB] FAIL restart_board: got %h/%0d required %h/0", dut_coords(), score, e.coords);
        end
      end
    end
    step();
    // rising edge on the correct lane while waiting for the draw, then held
    key = 4'b0001 << m_lane[3];
    step();
    step();
    dif.draw_done = 1'b1;
    step();
    dif.draw_done = 1'b0;
    play_cycles = 0;
    upd = 0;
    while (game_over !== 1'b1 && play_cycles < 40) begin
      play_cycles++;
      step();
      if (dif.update === 1'b1) upd++;
    end
    key = 4'b0000;
    n_checks++;
    if (play_cycles != 12 || upd != 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_cycles: got %0d play cycles %0d updates required 12 and 0", play_cycles, upd);
    end
    n_checks++;
    if (score !== 8'd0 || dut_coords() !== model_coords()) begin
      n_fail++;
      $display("[TB] FAIL timeout_frozen: got score=%0d coords=%h required 0/%h", score, dut_coords(), model_coords());
    end
  endtask

  task automatic test_multi_press();
    start_game();
    finish_start("multi_start");
    key = 4'b0101;
    step();
    key = 4'b0000;
    n_checks++;
    if (game_over !== 1'b1 || score !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL multi_press_over: got go=%b score=%0d required 1/0", game_over, score);
    end
  endtask

  task automatic test_saturation();
    int   cyc;
    bit   seen;
    exp_t e;
    start_game();
    finish_start("sat_start");
    for (int n = 0; n < 257; n++) begin
      key = 4'b0001 << m_lane[3];
      if (m_score != 8'hFF) m_score = m_score + 8'd1;
      model_gen();
      push_expected();
      wait_update(6, cyc, seen);
      key = 4'b0000;
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("[TB] FAIL sat_update: press %0d got no update, required one", n);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      n_checks++;
      if (dut_coords() !== e.coords || score !== e.score) begin
        n_fail++;
        $display("[TB] FAIL sat_board: press %0d got %h/%0d required %h/%0d", n, dut_coords(), score, e.coords, e.score);
      end
      step();
      pulse_draw_done();
    end
    n_checks++;
    if (score !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL sat_final: got score=%0d required 255", score);
    end
  endtask

  task automatic test_reset_wait_draw();
    int   cyc;
    bit   seen;
    int   upd;
    key = 4'b0001 << (m_lane[3] ^ 2'd2);
    step();
    key = 4'b0000;
    step();
    start_game();
    finish_start("rst_start");
    for (int n = 0; n < 5; n++) begin
      key = 4'b0001 << m_lane[3];
      m_score = m_score + 8'd1;
      model_gen();
      wait_update(6, cyc, seen);
      key = 4'b0000;
      step();
      if (n < 4) pulse_draw_done();
    end
    n_checks++;
    if (score !== 8'd5 || dut_coords() !== model_coords()) begin
      n_fail++;
      $display("[TB] FAIL pre_reset: got score=%0d coords=%h required 5/%h", score, dut_coords(), model_coords());
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (score !== 8'd0 || dut_coords() !== model_coords() || dif.update !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wait_draw_reset: got score=%0d coords=%h upd=%b go=%b required 0/%h/0/0",
               score, dut_coords(), dif.update, game_over, model_coords());
    end
    upd = 0;
    pulse_draw_done();
    for (int i = 0; i < 6; i++) begin
      if (dif.update === 1'b1) upd++;
      step();
    end
    n_checks++;
    if (upd != 0 || game_over !== 1'b0 || score !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL late_draw_done: got upd=%0d go=%b score=%0d required 0/0/0", upd, game_over, score);
    end
    // generator is back at its seed, so the first board repeats
    start_game();
    finish_start("post_reset");
  endtask

  initial begin
    dif.draw_done = 1'b0;
    test_reset();
    test_start_fill();
    test_correct_press();
    test_wrong_press();
    test_timeout();
    test_multi_press();
    test_saturation();
    test_reset_wait_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
